pe_array_flex: RTL and testbench

- Parametrised successor to the single mixed-radix butterfly PE: LANES independent butterfly lanes share one mode and one handshake.
- Supports the same five operations as the single PE (NTT, INTT, CWM, CODECO1/2, ADDSUB), with multiplier latency as a parameter.
- Adds a hardware mode interlock with an input ready: the AU controller no longer flushes manually before a mode switch.
- Sits between the AU controller/operand buffers and the polynomial RAM write-back path.

---
 rtl/pe_array_flex.sv | 199 +++++++++++++++++++
 tb/tb_pe_array_flex.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_flex.sv
// LANES-wide mixed-radix butterfly array with shared mode, handshake and a mode-switch interlock.
// Modular multiplier is MUL_LAT registers deep; results leave through one registered output stage.
package pe_array_flex_pkg;
  typedef enum logic [2:0] {
    MODE_NTT     = 3'd0,
    MODE_INTT    = 3'd1,
    MODE_CWM     = 3'd2,
    MODE_CODECO1 = 3'd3,
    MODE_CODECO2 = 3'd4,
    MODE_ADDSUB  = 3'd5
  } pe_mode_e;
endpackage

module pe_array_flex
  import pe_array_flex_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int COEFF_WIDTH = 12,
  parameter int Q           = 3329,
  parameter int MUL_LAT     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  pe_mode_e                     mode_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [LANES*COEFF_WIDTH-1:0] a_i,
  input  logic [LANES*COEFF_WIDTH-1:0] b_i,
  input  logic [LANES*COEFF_WIDTH-1:0] w_i,
  input  logic [LANES*COEFF_WIDTH-1:0] tf_i,
  output logic [LANES*COEFF_WIDTH-1:0] u_o,
  output logic [LANES*COEFF_WIDTH-1:0] v_o,
  output pe_mode_e                     mode_o,
  output logic                         valid_o,
  output logic                         busy_o
);
  localparam int W  = COEFF_WIDTH;
  localparam int DW = LANES * W;
  localparam int CW = $clog2(MUL_LAT + 2);

  typedef enum logic [1:0] {S_RESET_HOLD, S_IDLE, S_RUN, S_DRAIN} state_e;

  function automatic logic [W-1:0] add_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_q(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? (x - y) : W'({1'b0, x} + (W+1)'(Q) - {1'b0, y});
  endfunction

  function automatic logic [W-1:0] half_q(input logic [W-1:0] x);
    logic [W:0] t;
    t = {1'b0, x} + (x[0] ? (W+1)'(Q) : (W+1)'(0));
    return t[W:1];
  endfunction

  function automatic logic [W-1:0] mul_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(p % (2*W)'(Q));
  endfunction

  state_e          r_state, w_state_nxt;
  pe_mode_e        r_cur, w_mode;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_acc;

  logic [DW-1:0]   r_p [MUL_LAT];
  logic [DW-1:0]   r_s [MUL_LAT];
  logic            r_v [MUL_LAT];
  pe_mode_e        r_t [MUL_LAT];

  logic [DW-1:0]   w_prod, w_side, w_u_as, w_v_as, w_u_mul, w_v_mul, w_pd, w_sd;
  logic            w_vd, w_emit_as, w_emit_cd, w_emit_mul;
  pe_mode_e        w_td;

  always_comb begin
    w_mode = MODE_ADDSUB;
    case (mode_i)
      MODE_NTT, MODE_INTT, MODE_CWM, MODE_CODECO1, MODE_CODECO2: w_mode = mode_i;
      default: w_mode = MODE_ADDSUB;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    if (!rst && r_state != S_RESET_HOLD)
      ready_o = (r_cnt == '0) || (w_mode == r_cur);
    w_acc     = valid_i && ready_o;
    w_cnt_nxt = r_cnt + CW'(w_acc) - CW'(valid_o);
    if (r_state == S_RESET_HOLD)       w_state_nxt = S_IDLE;
    else if (w_cnt_nxt == '0)          w_state_nxt = S_IDLE;
    else if (valid_i && !w_acc)        w_state_nxt = S_DRAIN;
    else                               w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET_HOLD;
      r_cnt   <= '0;
      r_cur   <= MODE_ADDSUB;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc) r_cur <= w_mode;
    end
  end

  assign busy_o = (r_cnt != '0);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0] w_a, w_b, w_wsel, w_pl, w_sl;
    logic         w_last_intt;
    assign w_a    = a_i[k*W +: W];
    assign w_b    = b_i[k*W +: W];
    assign w_wsel = (w_mode == MODE_CWM || w_mode == MODE_CODECO2) ? tf_i[k*W +: W] : w_i[k*W +: W];
    // INTT multiplies the difference, so the twiddle product is aligned with the acceptance cycle.
    assign w_prod[k*W +: W] = mul_q((w_mode == MODE_INTT) ? sub_q(w_a, w_b) : w_b, w_wsel);
    assign w_side[k*W +: W] = (w_mode == MODE_INTT) ? half_q(add_q(w_a, w_b)) : w_a;
    assign w_u_as[k*W +: W] = add_q(w_a, w_b);
    assign w_v_as[k*W +: W] = sub_q(w_a, w_b);
    assign w_pl        = r_p[MUL_LAT-1][k*W +: W];
    assign w_sl        = r_s[MUL_LAT-1][k*W +: W];
    assign w_last_intt = (r_t[MUL_LAT-1] == MODE_INTT);
    assign w_u_mul[k*W +: W] = w_last_intt ? w_sl : add_q(w_sl, w_pl);
    assign w_v_mul[k*W +: W] = w_last_intt ? w_pl : sub_q(w_sl, w_pl);
  end

  // CODECO taps the value entering the last multiplier stage to finish one cycle early.
  if (MUL_LAT == 1) begin : g_tap_in
    assign w_pd = w_prod;
    assign w_sd = w_side;
    assign w_vd = w_acc;
    assign w_td = w_mode;
  end else begin : g_tap_pipe
    assign w_pd = r_p[MUL_LAT-2];
    assign w_sd = r_s[MUL_LAT-2];
    assign w_vd = r_v[MUL_LAT-2];
    assign w_td = r_t[MUL_LAT-2];
  end

  always_ff @(posedge clk) begin
    r_p[0] <= w_prod;
    r_s[0] <= w_side;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      r_p[i] <= r_p[i-1];
      r_s[i] <= r_s[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        r_v[i] <= 1'b0;
        r_t[i] <= pe_mode_e'(3'd0);
      end
    end else begin
      r_v[0] <= w_acc;
      r_t[0] <= w_mode;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_t[i] <= r_t[i-1];
      end
    end
  end

  assign w_emit_as  = w_acc && (w_mode == MODE_ADDSUB);
  assign w_emit_cd  = w_vd && (w_td == MODE_CODECO1 || w_td == MODE_CODECO2);
  assign w_emit_mul = r_v[MUL_LAT-1] &&
                      (r_t[MUL_LAT-1] == MODE_NTT || r_t[MUL_LAT-1] == MODE_INTT ||
                       r_t[MUL_LAT-1] == MODE_CWM);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      u_o     <= '0;
      v_o     <= '0;
      mode_o  <= pe_mode_e'(3'd0);
    end else begin
      valid_o <= w_emit_as || w_emit_cd || w_emit_mul;
      if (w_emit_as) begin
        u_o    <= w_u_as;
        v_o    <= w_v_as;
        mode_o <= MODE_ADDSUB;
      end else if (w_emit_cd) begin
        u_o    <= w_sd;
        v_o    <= w_pd;
        mode_o <= w_td;
      end else if (w_emit_mul) begin
        u_o    <= w_u_mul;
        v_o    <= w_v_mul;
        mode_o <= r_t[MUL_LAT-1];
      end
    end
  end
endmodule

// File: tb/tb_pe_array_flex.sv
// Self-checking bench for pe_array_flex: directed literal cases plus randomized traffic
// checked every cycle against a beat-level reference model.
module tb_pe_array_flex;
  import pe_array_flex_pkg::*;

  localparam int LANES   = 4;
  localparam int W       = 12;
  localparam int Q       = 3329;
  localparam int MUL_LAT = 3;
  localparam int DW      = LANES * W;

  logic            clk = 1'b0;
  logic            rst;
  pe_mode_e        mode_i;
  logic            valid_i;
  logic            ready_o;
  logic [DW-1:0]   a_i, b_i, w_i, tf_i, u_o, v_o;
  pe_mode_e        mode_o;
  logic            valid_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pe_array_flex #(.LANES(LANES), .COEFF_WIDTH(W), .Q(Q), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .w_i(w_i), .tf_i(tf_i),
    .u_o(u_o), .v_o(v_o), .mode_o(mode_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int norm(input int m);
    return (m > 5 || m < 0) ? 5 : m;
  endfunction

  function automatic int lat(input int m);
    if (m == 0 || m == 1 || m == 2) return MUL_LAT + 1;
    if (m == 3 || m == 4)           return MUL_LAT;
    return 1;
  endfunction

  function automatic void ref_lane(input int m, input int a, input int b, input int w, input int tf,
                                   output int u, output int v);
    int ws, p, s;
    ws = (m == 2 || m == 4) ? tf : w;
    case (m)
      0, 2: begin p = (b * ws) % Q; u = (a + p) % Q; v = (a - p + Q) % Q; end
      1: begin
        s = (a + b) % Q;
        u = (s % 2 == 0) ? s / 2 : (s + Q) / 2;
        v = (((a - b + Q) % Q) * ws) % Q;
      end
      3, 4: begin u = a; v = (b * ws) % Q; end
      default: begin u = (a + b) % Q; v = (a - b + Q) % Q; end
    endcase
  endfunction

  typedef struct {
    int            emit;
    int            mode;
    logic [DW-1:0] u;
    logic [DW-1:0] v;
  } beat_t;

  beat_t q[$];
  int    cur     = 5;
  bit    hold    = 1'b0;
  bit    started = 1'b0;

  always @(negedge clk) begin
    int    nm, uu, vv;
    bit    er, ev;
    beat_t bt;
    nm = norm(int'(mode_i));
    if (rst) begin
      chk("ready_during_rst", int'(ready_o), 0);
      q.delete();
      cur     = 5;
      hold    = 1'b1;
      started = 1'b1;
    end else if (started) begin
      er = !hold && (q.size() == 0 || nm == cur);
      chk("ready", int'(ready_o), int'(er));
      chk("busy", int'(busy_o), int'(q.size() != 0));
      ev = (q.size() > 0) && (q[0].emit == cyc);
      chk("valid", int'(valid_o), int'(ev));
      if (ev) begin
        bt = q.pop_front();
        chk("mode_o", int'(mode_o), bt.mode);
        for (int k = 0; k < LANES; k++) begin
          chk("u_lane", int'(u_o[k*W +: W]), int'(bt.u[k*W +: W]));
          chk("v_lane", int'(v_o[k*W +: W]), int'(bt.v[k*W +: W]));
        end
      end
      if (valid_i && er) begin
        bt.emit = cyc + lat(nm);
        bt.mode = nm;
        for (int k = 0; k < LANES; k++) begin
          ref_lane(nm, int'(a_i[k*W +: W]), int'(b_i[k*W +: W]), int'(w_i[k*W +: W]),
                   int'(tf_i[k*W +: W]), uu, vv);
          bt.u[k*W +: W] = W'(uu);
          bt.v[k*W +: W] = W'(vv);
        end
        q.push_back(bt);
        cur = nm;
      end
      hold = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input bit vld, input int a, input int b, input int w, input int tf);
    mode_i  = pe_mode_e'(3'(m));
    valid_i = vld;
    for (int k = 0; k < LANES; k++) begin
      a_i[k*W +: W]  = W'(a);
      b_i[k*W +: W]  = W'(b);
      w_i[k*W +: W]  = W'(w);
      tf_i[k*W +: W] = W'(tf);
    end
  endtask

  task automatic drive_rand(input int m, input bit vld);
    mode_i  = pe_mode_e'(3'(m));
    valid_i = vld;
    for (int k = 0; k < LANES; k++) begin
      a_i[k*W +: W]  = W'($urandom_range(0, Q-1));
      b_i[k*W +: W]  = W'($urandom_range(0, Q-1));
      w_i[k*W +: W]  = W'($urandom_range(0, Q-1));
      tf_i[k*W +: W] = W'($urandom_range(0, Q-1));
    end
  endtask

  task automatic one_beat(input string name, input int m, input int a, input int b, input int w,
                          input int tf, input int l, input int eu, input int ev);
    drive(m, 1'b1, a, b, w, tf);
    tick();
    valid_i = 1'b0;
    repeat (l - 1) tick();
    #2;
    chk({name, "_valid"}, int'(valid_o), 1);
    chk({name, "_mode"}, int'(mode_o), m);
    chk({name, "_u0"}, int'(u_o[W-1:0]), eu);
    chk({name, "_v0"}, int'(v_o[W-1:0]), ev);
    chk({name, "_u_last"}, int'(u_o[(LANES-1)*W +: W]), eu);
    chk({name, "_v_last"}, int'(v_o[(LANES-1)*W +: W]), ev);
    tick();
    #2;
    chk({name, "_valid_drop"}, int'(valid_o), 0);
    tick();
  endtask

  initial begin
    int waits, cm;
    rst = 1'b1;
    drive(5, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    #2;
    chk("hold_ready", int'(ready_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_u", int'(u_o[W-1:0]), 0);
    chk("rst_mode", int'(mode_o), 0);
    tick();
    #2;
    chk("idle_ready", int'(ready_o), 1);
    tick();

    one_beat("ntt",      0, 1,    2,   3,  0, 4, 7,    3324);
    one_beat("intt",     1, 5,    3,   10, 0, 4, 4,    20);
    one_beat("intt_odd", 1, 0,    1,   1,  0, 4, 1665, 3328);
    one_beat("addsub",   5, 3000, 500, 0,  0, 1, 171,  2500);

    for (int i = 0; i < 16; i++) begin
      drive_rand(5, 1'b1);
      #2;
      chk("stream_ready", int'(ready_o), 1);
      tick();
    end
    valid_i = 1'b0;
    repeat (2) tick();

    one_beat("codeco2", 4, 100, 7, 5, 9, 3, 100, 63);
    one_beat("cwm",     2, 100, 7, 5, 9, 4, 163, 37);

    for (int i = 0; i < 3; i++) begin
      drive_rand(0, 1'b1);
      tick();
    end
    drive_rand(5, 1'b1);
    waits = 0;
    #2;
    while (ready_o !== 1'b1 && waits < 20) begin
      tick();
      #2;
      waits++;
    end
    chk("switch_wait_cycles", waits, 4);
    tick();
    valid_i = 1'b0;
    repeat (3) tick();

    drive_rand(0, 1'b1);
    tick();
    drive_rand(0, 1'b1);
    tick();
    valid_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("midop_rst_ready", int'(ready_o), 0);
    tick();
    rst = 1'b0;
    #2;
    chk("midop_hold_ready", int'(ready_o), 0);
    tick();
    one_beat("post_rst_ntt", 0, 1, 2, 3, 0, 4, 7, 3324);

    cm = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) cm = int'($urandom_range(0, 7));
      drive_rand(cm, $urandom_range(0, 3) != 0);
      tick();
    end
    valid_i = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
